// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution window sequencer.
// The state enum encodes the RAM read/compute/write handshake cycle of one window.
package cnn_pkg;

  localparam int WIN_K      = 5;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_REQ  = 4'd1,
    RD_WAIT = 4'd2,
    RD_REL  = 4'd3,
    COMPUTE = 4'd4,
    WR_REQ  = 4'd5,
    WR_WAIT = 4'd6,
    WR_REL  = 4'd7,
    DONE    = 4'd8
  } seq_state_e;

endpackage

// File: rtl/window_pos_counter.sv
// Row/column/output-index tracker for the KxK window walk.
// Also produces the window read address and flags the final window position.
module window_pos_counter
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int K      = WIN_K
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] width,
  input  logic [ADDR_W-1:0] height,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] idx,
  output logic              is_last
);

  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] c_max_s;
  logic [ADDR_W-1:0] r_max_s;

  assign c_max_s = width - ADDR_W'(K);
  assign r_max_s = height - ADDR_W'(K);
  assign is_last = (r_q == r_max_s) && (c_q == c_max_s);
  // Address arithmetic deliberately wraps modulo 2^ADDR_W.
  assign rd_addr = base + r_q * width + c_q;
  assign idx     = idx_q;

  // Next-position computation: clear on layer start, step in raster order on advance.
  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    idx_d = idx_q;
    if (clear) begin
      r_d   = '0;
      c_d   = '0;
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + ADDR_W'(1);
      if (c_q == c_max_s) begin
        c_d = '0;
        r_d = r_q + ADDR_W'(1);
      end else begin
        c_d = c_q + ADDR_W'(1);
        r_d = r_q;
      end
    end else begin
      r_d   = r_q;
      c_d   = c_q;
      idx_d = idx_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      c_q   <= '0;
      idx_q <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Drives the shared RAM through one convolution layer: window read, datapath
// hand-off, result write-back, repeated for every valid KxK window position.
module conv_window_sequencer
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = WIN_K
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] img_width,
  input  logic [ADDR_W-1:0] img_height,
  input  logic [ADDR_W-1:0] out_base,
  output logic              ram_enable,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [ADDR_W-1:0] ram_offset,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_finish,
  output logic              win_valid,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_flag_q, err_flag_d;
  logic              win_valid_q, win_valid_d;
  logic              ram_enable_q, ram_enable_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [ADDR_W-1:0] ram_offset_q, ram_offset_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] cfg_base_q, cfg_base_d;
  logic [ADDR_W-1:0] cfg_width_q, cfg_width_d;
  logic [ADDR_W-1:0] cfg_height_q, cfg_height_d;
  logic [ADDR_W-1:0] cfg_out_q, cfg_out_d;

  logic              pos_clear_s;
  logic              pos_adv_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] idx_s;
  logic              is_last_s;
  logic              cfg_small_s;

  assign cfg_small_s = (img_width < ADDR_W'(K)) || (img_height < ADDR_W'(K));

  window_pos_counter #(
    .ADDR_W (ADDR_W),
    .K      (K)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pos_clear_s),
    .advance (pos_adv_s),
    .base    (cfg_base_q),
    .width   (cfg_width_q),
    .height  (cfg_height_q),
    .rd_addr (rd_addr_s),
    .idx     (idx_s),
    .is_last (is_last_s)
  );

  // Next-state and next-output logic for the per-window RAM handshake.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_flag_d    = err_flag_q;
    win_valid_d   = 1'b0;
    ram_enable_d  = ram_enable_q;
    ram_write_d   = ram_write_q;
    ram_address_d = ram_address_q;
    ram_offset_d  = ram_offset_q;
    ram_wdata_d   = ram_wdata_q;
    cfg_base_d    = cfg_base_q;
    cfg_width_d   = cfg_width_q;
    cfg_height_d  = cfg_height_q;
    cfg_out_d     = cfg_out_q;
    pos_clear_s   = 1'b0;
    pos_adv_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_base_d   = img_base;
          cfg_width_d  = img_width;
          cfg_height_d = img_height;
          cfg_out_d    = out_base;
          busy_d       = 1'b1;
          pos_clear_s  = 1'b1;
          if (cfg_small_s) begin
            err_flag_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_flag_d = 1'b0;
            state_d    = RD_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        ram_enable_d  = 1'b1;
        ram_write_d   = 1'b0;
        ram_address_d = rd_addr_s;
        ram_offset_d  = cfg_width_q;
        state_d       = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_finish) begin
          ram_enable_d = 1'b0;
          state_d      = RD_REL;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_REL: begin
        win_valid_d = 1'b1;
        state_d     = COMPUTE;
      end
      COMPUTE: begin
        if (res_valid) begin
          ram_wdata_d = res_data;
          state_d     = WR_REQ;
        end else begin
          state_d = COMPUTE;
        end
      end
      WR_REQ: begin
        ram_enable_d  = 1'b1;
        ram_write_d   = 1'b1;
        ram_address_d = cfg_out_q + idx_s;
        state_d       = WR_WAIT;
      end
      WR_WAIT: begin
        if (ram_finish) begin
          ram_enable_d = 1'b0;
          ram_write_d  = 1'b0;
          state_d      = WR_REL;
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_REL: begin
        pos_adv_s = 1'b1;
        if (is_last_s) begin
          state_d = DONE;
        end else begin
          state_d = RD_REQ;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        err_d      = err_flag_q;
        err_flag_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        ram_enable_d = 1'b0;
        ram_write_d  = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, configuration and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_flag_q    <= 1'b0;
      win_valid_q   <= 1'b0;
      ram_enable_q  <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_offset_q  <= '0;
      ram_wdata_q   <= '0;
      cfg_base_q    <= '0;
      cfg_width_q   <= '0;
      cfg_height_q  <= '0;
      cfg_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_flag_q    <= err_flag_d;
      win_valid_q   <= win_valid_d;
      ram_enable_q  <= ram_enable_d;
      ram_write_q   <= ram_write_d;
      ram_address_q <= ram_address_d;
      ram_offset_q  <= ram_offset_d;
      ram_wdata_q   <= ram_wdata_d;
      cfg_base_q    <= cfg_base_d;
      cfg_width_q   <= cfg_width_d;
      cfg_height_q  <= cfg_height_d;
      cfg_out_q     <= cfg_out_d;
    end
  end

  assign ram_enable  = ram_enable_q;
  assign ram_write   = ram_write_q;
  assign ram_address = ram_address_q;
  assign ram_offset  = ram_offset_q;
  assign ram_wdata   = ram_wdata_q;
  assign win_valid   = win_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Table-driven bench for conv_window_sequencer with a behavioural RAM and datapath
// responder; expected transactions come from a raster-order window model.
module tb_conv_window_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] img_base, img_width, img_height, out_base;
  logic        ram_enable, ram_write;
  logic [15:0] ram_address, ram_offset, ram_wdata;
  logic        ram_finish;
  logic        win_valid;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy, done, err;

  logic        dp_valid, inj_valid;
  logic [15:0] dp_data, inj_data;
  assign res_valid = dp_valid | inj_valid;
  assign res_data  = inj_valid ? inj_data : dp_data;

  conv_window_sequencer #(.ADDR_W(16), .DATA_W(16), .K(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_base    (img_base),
    .img_width   (img_width),
    .img_height  (img_height),
    .out_base    (out_base),
    .ram_enable  (ram_enable),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_offset  (ram_offset),
    .ram_wdata   (ram_wdata),
    .ram_finish  (ram_finish),
    .win_valid   (win_valid),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic [15:0] w, h, ib, ob, seed, exp_rd0;
    int          exp_win;
    logic        exp_err;
    int          ram_lat;
    int          dp_lat;
    bit          inj;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr, off, wd;
  } txn_t;

  vec_t        vecs[7];
  txn_t        log_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          clr_tok = 0;
  int          ram_lat = 0;
  int          dp_lat = 0;
  int          stall_read = -1;
  int          en_cycles;
  int          done_cnt = 0;
  logic [15:0] seed = 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM responder: raises finish ram_lat cycles after enable, drops it when enable falls.
  initial begin
    int wcnt, rd_done, seen;
    ram_finish = 1'b0; wcnt = 0; rd_done = 0; seen = 0; en_cycles = 0;
    forever begin
      @(posedge clk); #1;
      if (seen != clr_tok) begin
        seen = clr_tok; log_q.delete(); rd_done = 0; en_cycles = 0;
      end
      if (!rst_n) begin
        ram_finish = 1'b0; wcnt = 0;
      end else if (ram_enable) begin
        en_cycles++;
        if (!ram_finish) begin
          if (!ram_write && rd_done == stall_read) begin
            wcnt = 0;
          end else if (wcnt >= ram_lat) begin
            ram_finish = 1'b1; wcnt = 0;
            log_q.push_back('{ram_write, ram_address, ram_offset, ram_wdata});
            if (!ram_write) rd_done++;
          end else begin
            wcnt++;
          end
        end
      end else begin
        ram_finish = 1'b0; wcnt = 0;
      end
    end
  end

  // Datapath responder: returns seed+n dp_lat cycles after each win_valid.
  initial begin
    int res_n, seen;
    dp_valid = 1'b0; dp_data = 16'h0000; res_n = 0; seen = 0;
    forever begin
      @(posedge clk); #1;
      if (seen != clr_tok) begin
        seen = clr_tok; res_n = 0;
      end
      if (win_valid && rst_n) begin
        for (int j = 0; j < dp_lat; j++) begin
          @(posedge clk); #1;
        end
        dp_valid = 1'b1; dp_data = seed + 16'(res_n); res_n++;
        @(posedge clk); #1;
        dp_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
  end

  task automatic run_layer(input vec_t v, input int tag);
    int          cyc, d0, k;
    bit          seen_done, inj_done;
    logic        e_seen;
    logic [15:0] ea;
    clr_tok++;
    ram_lat = v.ram_lat; dp_lat = v.dp_lat; seed = v.seed;
    img_base = v.ib; img_width = v.w; img_height = v.h; out_base = v.ob;
    @(posedge clk); #1;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Changing the config after the accepted start must not affect the layer.
    img_base = 16'h5A5A; img_width = 16'h0003; img_height = 16'h0002; out_base = 16'hA5A5;
    chk($sformatf("v%0d_busy_after_start", tag), busy, 1);
    cyc = 1; seen_done = 0; inj_done = 0; e_seen = 1'b0;
    while (!seen_done && cyc < 3000) begin
      if (done) begin
        seen_done = 1; e_seen = err;
      end else begin
        if (inj_valid) begin
          inj_valid = 1'b0; start = 1'b0;
        end else if (v.inj && !inj_done && ram_enable && !ram_write && !ram_finish) begin
          inj_valid = 1'b1; inj_data = 16'hDEAD; start = 1'b1; inj_done = 1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    inj_valid = 1'b0; start = 1'b0;
    chk($sformatf("v%0d_done_seen", tag), seen_done, 1);
    chk($sformatf("v%0d_err", tag), e_seen, v.exp_err);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err_latency_le2", tag), cyc <= 2, 1);
      chk($sformatf("v%0d_no_ram_activity", tag), en_cycles, 0);
    end
    chk($sformatf("v%0d_txn_count", tag), log_q.size(), 2 * v.exp_win);
    if (v.exp_win > 0 && log_q.size() > 0)
      chk($sformatf("v%0d_first_read_addr", tag), log_q[0].addr, v.exp_rd0);
    k = 0;
    if (!v.exp_err) begin
      for (int r = 0; r <= int'(v.h) - 5; r++) begin
        for (int c = 0; c <= int'(v.w) - 5; c++) begin
          if (2 * k + 1 < log_q.size()) begin
            ea = v.ib + 16'(r) * v.w + 16'(c);
            chk($sformatf("v%0d_w%0d_rd_is_read", tag, k), log_q[2*k].wr, 0);
            chk($sformatf("v%0d_w%0d_rd_addr", tag, k), log_q[2*k].addr, ea);
            chk($sformatf("v%0d_w%0d_rd_off", tag, k), log_q[2*k].off, v.w);
            chk($sformatf("v%0d_w%0d_wr_is_write", tag, k), log_q[2*k+1].wr, 1);
            chk($sformatf("v%0d_w%0d_wr_addr", tag, k), log_q[2*k+1].addr, v.ob + 16'(k));
            chk($sformatf("v%0d_w%0d_wr_data", tag, k), log_q[2*k+1].wd, v.seed + 16'(k));
          end
          k++;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_busy_cleared", tag), busy, 0);
    chk($sformatf("v%0d_done_once", tag), done_cnt - d0, 1);
  endtask

  initial begin
    int cyc;
    //            w       h       ib      ob      seed    rd0   win err lat dp inj
    vecs[0] = '{16'd5, 16'd5, 16'h0100, 16'h0800, 16'h1234, 16'h0100, 1, 1'b0, 0, 0, 1'b0};
    vecs[1] = '{16'd7, 16'd6, 16'h0000, 16'h0200, 16'hA000, 16'h0000, 6, 1'b0, 0, 1, 1'b0};
    vecs[2] = '{16'd4, 16'd8, 16'h0010, 16'h0300, 16'h0000, 16'h0000, 0, 1'b1, 0, 0, 1'b0};
    vecs[3] = '{16'd6, 16'd5, 16'h0040, 16'h0400, 16'h7000, 16'h0040, 2, 1'b0, 3, 2, 1'b1};
    vecs[4] = '{16'd5, 16'd5, 16'hFFFE, 16'h0500, 16'h0001, 16'hFFFE, 1, 1'b0, 0, 0, 1'b0};
    vecs[5] = '{16'd6, 16'd5, 16'hFFFE, 16'h0600, 16'h0002, 16'hFFFE, 2, 1'b0, 1, 0, 1'b0};
    vecs[6] = '{16'd6, 16'd4, 16'h0000, 16'h0700, 16'h0000, 16'h0000, 0, 1'b1, 0, 0, 1'b0};

    rst_n = 1'b0; start = 1'b0; inj_valid = 1'b0; inj_data = 16'h0000;
    img_base = 16'h0000; img_width = 16'h0000; img_height = 16'h0000; out_base = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_enable", ram_enable, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_offset", ram_offset, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_layer(vecs[i], i);

    // Reset while the third window read is stalled in the RAM.
    clr_tok++;
    ram_lat = 0; dp_lat = 0; seed = 16'h0000; stall_read = 2;
    img_base = 16'h0000; img_width = 16'd7; img_height = 16'd6; out_base = 16'h0040;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(log_q.size() == 4 && ram_enable && !ram_write) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstmid_reached_stall", cyc < 500, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ram_enable_async", ram_enable, 0);
    chk("rstmid_busy_async", busy, 0);
    chk("rstmid_win_valid_async", win_valid, 0);
    chk("rstmid_ram_write_async", ram_write, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; stall_read = -1;
    run_layer(vecs[1], 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
